// File: rtl/count_monitor_if.sv
// Bundle between a count source and the count_monitor block.
// master drives the sample stream, slave is the monitor.
interface count_monitor_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [WIDTH-1:0] count;
    logic             clr_stat;
    logic [1:0]       state;
    logic             locked;
    logic             err;
    logic [7:0]       err_cnt;
    logic [7:0]       wrap_cnt;

    modport master (
        output en, count, clr_stat,
        input  state, locked, err, err_cnt, wrap_cnt
    );

    modport slave (
        input  en, count, clr_stat,
        output state, locked, err, err_cnt, wrap_cnt
    );
endinterface

// File: rtl/count_monitor.sv
// Watches an up-counter stream, locks after LOCK_N consecutive +1 steps,
// and flags and counts sequence breaks and rollovers while locked.
//
// state   | meaning
// IDLE    | no reference sample yet
// ACQUIRE | counting consecutive good steps toward lock
// LOCKED  | stream tracked; breaks raise err
// FAULT   | break seen while locked; waiting for a good step
module count_monitor #(
    parameter int WIDTH  = 4,
    parameter int LOCK_N = 3
) (
    input logic            clk,
    input logic            rst,
    count_monitor_if.slave mon
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    state_t           state_q, state_nxt;
    logic [WIDTH-1:0] prev_q, prev_nxt;
    logic [3:0]       match_q, match_nxt;
    logic             err_q, err_nxt;
    logic             locked_q;
    logic [7:0]       err_cnt_q, err_cnt_nxt;
    logic [7:0]       wrap_cnt_q, wrap_cnt_nxt;

    logic [WIDTH-1:0] prev_inc;
    logic [4:0]       match_inc;
    logic             good;
    logic             rollover;

    assign prev_inc  = prev_q + WIDTH'(1);
    assign good      = (mon.count == prev_inc);
    assign rollover  = good && (mon.count == '0);
    assign match_inc = {1'b0, match_q} + 5'd1;

    always_comb begin
        state_nxt    = state_q;
        prev_nxt     = prev_q;
        match_nxt    = match_q;
        err_nxt      = 1'b0;
        err_cnt_nxt  = err_cnt_q;
        wrap_cnt_nxt = wrap_cnt_q;
        if (mon.en) begin
            prev_nxt = mon.count;
            unique case (state_q)
                IDLE: begin
                    match_nxt = 4'd0;
                    state_nxt = ACQUIRE;
                end
                ACQUIRE: begin
                    if (good) begin
                        match_nxt = match_inc[3:0];
                        if (match_inc == 5'(LOCK_N)) state_nxt = LOCKED;
                    end else begin
                        match_nxt = 4'd0;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        if (rollover) wrap_cnt_nxt = wrap_cnt_q + 8'd1;
                    end else begin
                        err_nxt     = 1'b1;
                        err_cnt_nxt = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                        state_nxt   = FAULT;
                    end
                end
                FAULT: begin
                    if (good) begin
                        match_nxt = 4'd1;
                        state_nxt = (LOCK_N == 1) ? LOCKED : ACQUIRE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        // clear overrides any increment computed above, but not err or the FSM
        if (mon.clr_stat) begin
            err_cnt_nxt  = 8'd0;
            wrap_cnt_nxt = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            match_q    <= 4'd0;
            err_q      <= 1'b0;
            locked_q   <= 1'b0;
            err_cnt_q  <= 8'd0;
            wrap_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_nxt;
            prev_q     <= prev_nxt;
            match_q    <= match_nxt;
            err_q      <= err_nxt;
            locked_q   <= (state_nxt == LOCKED);
            err_cnt_q  <= err_cnt_nxt;
            wrap_cnt_q <= wrap_cnt_nxt;
        end
    end

    assign mon.state    = state_q;
    assign mon.locked   = locked_q;
    assign mon.err      = err_q;
    assign mon.err_cnt  = err_cnt_q;
    assign mon.wrap_cnt = wrap_cnt_q;
endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor (WIDTH=4, LOCK_N=3): vector table plus
// hand-written saturation and asynchronous-reset sequences.
module tb_count_monitor;
    logic clk = 1'b0;
    logic rst = 1'b0;

    count_monitor_if #(.WIDTH(4)) bus ();

    count_monitor #(.WIDTH(4), .LOCK_N(3)) dut (
        .clk (clk),
        .rst (rst),
        .mon (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] cnt;
        logic       clr;
        logic [1:0] st;
        logic       lk;
        logic       err;
        logic [7:0] ec;
        logic [7:0] wc;
    } vec_t;

    vec_t vq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic void add(logic e, int c, logic cl, int st, logic lk, logic er, int ec, int wc);
        vec_t v;
        v.en = e; v.cnt = 4'(c); v.clr = cl; v.st = 2'(st);
        v.lk = lk; v.err = er; v.ec = 8'(ec); v.wc = 8'(wc);
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input logic e, input int c, input logic cl);
        bus.en = e; bus.count = 4'(c); bus.clr_stat = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int st, input int lk, input int er, input int ec, input int wc);
        chk({tag, ".state"},    int'(bus.state),    st);
        chk({tag, ".locked"},   int'(bus.locked),   lk);
        chk({tag, ".err"},      int'(bus.err),      er);
        chk({tag, ".err_cnt"},  int'(bus.err_cnt),  ec);
        chk({tag, ".wrap_cnt"}, int'(bus.wrap_cnt), wc);
    endtask

    initial begin
        int c;
        int exp_ec;
        bus.en = 1'b0; bus.count = '0; bus.clr_stat = 1'b0;

        // acquire and lock on 0..3
        add(1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0, 0);
        add(1, 2, 0, 1, 0, 0, 0, 0);
        add(1, 3, 0, 2, 1, 0, 0, 0);
        for (int i = 4; i <= 15; i++) add(1, i, 0, 2, 1, 0, 0, 0);
        add(1, 0, 0, 2, 1, 0, 0, 1);
        add(1, 1, 0, 2, 1, 0, 0, 1);
        for (int i = 2; i <= 6; i++) add(1, i, 0, 2, 1, 0, 0, 1);
        // break 6 -> 9, recover on 10,11,12
        add(1, 9,  0, 3, 0, 1, 1, 1);
        add(1, 10, 0, 1, 0, 0, 1, 1);
        add(1, 11, 0, 1, 0, 0, 1, 1);
        add(1, 12, 0, 2, 1, 0, 1, 1);
        // repeated value is a break; repeat in ACQUIRE resets the match run
        add(1, 12, 0, 3, 0, 1, 2, 1);
        add(1, 13, 0, 1, 0, 0, 2, 1);
        add(1, 13, 0, 1, 0, 0, 2, 1);
        add(1, 14, 0, 1, 0, 0, 2, 1);
        add(1, 15, 0, 1, 0, 0, 2, 1);
        add(1, 0,  0, 2, 1, 0, 2, 1);
        // bad step while in FAULT: no extra err
        add(1, 5, 0, 3, 0, 1, 3, 1);
        add(1, 7, 0, 3, 0, 0, 3, 1);
        add(1, 8, 0, 1, 0, 0, 3, 1);
        add(1, 9, 0, 1, 0, 0, 3, 1);
        add(1, 10, 0, 2, 1, 0, 3, 1);
        // en low while count advances, then the resumed sample is a break
        for (int i = 11; i <= 14; i++) add(0, i, 0, 2, 1, 0, 3, 1);
        add(1, 15, 0, 3, 0, 1, 4, 1);
        add(1, 0, 0, 1, 0, 0, 4, 1);
        add(1, 1, 0, 1, 0, 0, 4, 1);
        add(1, 2, 0, 2, 1, 0, 4, 1);
        for (int i = 3; i <= 15; i++) add(1, i, 0, 2, 1, 0, 4, 1);
        // clear wins over a same-cycle rollover increment
        add(1, 0, 1, 2, 1, 0, 0, 0);
        add(1, 1, 0, 2, 1, 0, 0, 0);
        // clear coincident with a break: err still pulses
        add(1, 3, 1, 3, 0, 1, 0, 0);

        #12;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vq[i]) begin
            step(vq[i].en, int'(vq[i].cnt), vq[i].clr);
            chk_all($sformatf("vec%0d", i), vq[i].st, vq[i].lk, vq[i].err, vq[i].ec, vq[i].wc);
        end

        // saturation: 256 break/relock cycles from FAULT with prev=3
        step(1, 4, 0); step(1, 5, 0); step(1, 6, 0);
        chk("sat.prelock", int'(bus.state), 2);
        c = 6;
        for (int i = 0; i < 256; i++) begin
            c = (c + 2) % 16;
            step(1, c, 0);
            exp_ec = (i + 1 > 255) ? 255 : i + 1;
            if (i < 3 || i > 252) begin
                chk($sformatf("sat%0d.err", i), int'(bus.err), 1);
                chk($sformatf("sat%0d.err_cnt", i), int'(bus.err_cnt), exp_ec);
            end
            for (int k = 0; k < 3; k++) begin
                c = (c + 1) % 16;
                step(1, c, 0);
            end
        end
        chk("sat.err_cnt", int'(bus.err_cnt), 255);
        chk("sat.state", int'(bus.state), 2);
        c = (c + 3) % 16;
        step(1, c, 1);
        chk_all("satclr", 3, 0, 1, 0, 0);
        c = (c + 1) % 16;
        step(1, c, 0);
        chk("satclr.err_drop", int'(bus.err), 0);

        // async reset while LOCKED with err_cnt=3 and wrap_cnt=1
        rst = 1'b0; #3; rst = 1'b1;
        @(posedge clk); #1;
        step(1, 0, 0); step(1, 1, 0); step(1, 2, 0); step(1, 3, 0);
        c = 3;
        for (int i = 0; i < 3; i++) begin
            c = (c + 5) % 16;
            step(1, c, 0);
            for (int k = 0; k < 3; k++) begin
                c = (c + 1) % 16;
                step(1, c, 0);
            end
        end
        while (c != 0) begin
            c = (c + 1) % 16;
            step(1, c, 0);
        end
        chk_all("prerst", 2, 1, 0, 3, 1);
        #3;
        rst = 1'b0;
        #1;
        chk_all("asyncrst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        step(1, 7, 0);
        chk_all("relock0", 1, 0, 0, 0, 0);
        step(1, 8, 0);
        chk("relock1.state", int'(bus.state), 1);
        step(1, 9, 0);
        chk("relock2.state", int'(bus.state), 1);
        step(1, 10, 0);
        chk_all("relock3", 2, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter WIDTH, default 4: width of the monitored count bus.
REQ-002 Parameter LOCK_N, default 3: consecutive correct increments required to lock (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 en  input  1  sample qualifier; count is evaluated only on edges where en=1.
REQ-006 count  input  WIDTH  count stream from the up-counter under observation.
REQ-007 clr_stat  input  1  synchronous clear of the statistics counters.
REQ-008 state  output  2  FSM state: IDLE=0, ACQUIRE=1, LOCKED=2, FAULT=3.
REQ-009 locked  output  1  high while state=LOCKED.
REQ-010 err  output  1  one-cycle pulse on a sequence break detected while LOCKED.
REQ-011 err_cnt  output  8  error count, saturating at 255.
REQ-012 wrap_cnt  output  8  count of observed (2^WIDTH-1)->0 rollovers while LOCKED, wraps 255->0.

Function
REQ-013 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-014 Internal regs: prev (WIDTH bits, last sampled count) and match_cnt (4 bits).
REQ-015 "Good step" SHALL mean count == (prev+1) mod 2^WIDTH; rollover 2^WIDTH-1 -> 0 is a good step.
REQ-016 en=0: state, prev, match_cnt, err_cnt and wrap_cnt SHALL hold, and err SHALL be 0.
REQ-017 IDLE, en=1: prev<=count, match_cnt<=0, go to ACQUIRE.
REQ-018 ACQUIRE, en=1, good step: match_cnt<=match_cnt+1; if match_cnt+1==LOCK_N, go to LOCKED.
REQ-019 ACQUIRE, en=1, bad step: match_cnt<=0, stay in ACQUIRE, no err pulse, err_cnt unchanged.
REQ-020 LOCKED, en=1, good step: stay LOCKED; if the step is the rollover, wrap_cnt<=wrap_cnt+1.
REQ-021 LOCKED, en=1, bad step: err=1 for exactly one cycle, err_cnt increments (saturating), go to FAULT.
REQ-022 FAULT, en=1, good step: match_cnt<=1 and go to ACQUIRE (go directly to LOCKED if LOCK_N==1).
REQ-023 FAULT, en=1, bad step: stay in FAULT, no further err pulse, err_cnt unchanged.
REQ-024 prev<=count on every edge with en=1, in every state.
REQ-025 clr_stat=1: err_cnt<=0 and wrap_cnt<=0; clear SHALL win over a same-cycle increment; the err pulse and the FSM transition SHALL still occur.
REQ-026 clr_stat SHALL NOT affect state, prev, match_cnt or locked.
REQ-027 A repeated value (count==prev) SHALL be a bad step.

Reset
REQ-028 rst=0 SHALL immediately, without waiting for clk, force state=IDLE, locked=0, err=0, err_cnt=0, wrap_cnt=0, prev=0, match_cnt=0.
REQ-029 Reset asserted mid-operation SHALL discard lock and statistics; reacquisition after release starts from IDLE.
REQ-030 Release of rst SHALL take effect on the next rising clk; the first en=1 sample after release is treated as an IDLE sample.

Verification
REQ-031 Reset, then en=1 with count 0,1,2,3 on successive edges -> state IDLE->ACQUIRE->ACQUIRE->ACQUIRE->LOCKED; locked=1 after the edge that samples 3; err=0 throughout.
REQ-032 Locked stream ...14,15,0,1 -> wrap_cnt 0->1 after the edge that samples 0; locked stays 1; err=0.
REQ-033 Locked stream 5,6,9,10,11 -> err=1 for one cycle after the edge that samples 9; err_cnt=1; FAULT; then ACQUIRE after 10; LOCKED again after 11+1 more good samples (LOCK_N=3).
REQ-034 en toggled 0 for 4 cycles while count keeps advancing, then en=1 -> first sample is a bad step; err pulses once and err_cnt=1.
REQ-035 Force 256 LOCKED->FAULT->relock cycles -> err_cnt saturates at 255; then clr_stat coincident with an error -> err_cnt=0 and err pulses.
REQ-036 rst=0 asserted between clock edges while LOCKED with err_cnt=3 -> all outputs 0 before the next edge; relock requires the full IDLE+LOCK_N sequence.
